// File: rtl/clmul_incr_seq.sv
// -----------------------------------------------------------------------------
// clmul_incr_seq
//
// Sequential carry-less multiply / increment cell. An operand set {a, b, c} is
// accepted over a valid/ready handshake. The block then walks a one bit per
// cycle, XOR-accumulating shifted copies of b to form the GF(2) product a (x) b.
// In parallel with the accept it registers the increment b + c with carry-out.
//
// Optional feature (macro CLMUL_FULL_PRODUCT_EN):
//   defined   -> 2*WIDTH-bit accumulator and an extra output h_hi carrying the
//                upper WIDTH bits of the full carry-less product.
//   undefined -> WIDTH-bit accumulator, no h_hi port.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready is high only in IDLE. out_valid
// is high only in DONE and stays high, with results held, until out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand set presented
//   in_ready   block can accept operands (IDLE)
//   a          multiplicand, WIDTH bits
//   b          multiplier and increment operand, WIDTH bits
//   c          increment carry-in
//   out_valid  results valid (DONE)
//   out_ready  consumer accepts results
//   h          low WIDTH bits of a (x) b (carry-less)
//   h_hi       upper WIDTH bits of a (x) b (only with CLMUL_FULL_PRODUCT_EN)
//   m          (b + c) mod 2^WIDTH
//   m_cout     carry-out of b + c
//   busy       high in CALC or DONE
//
// The FSM state is held in the signal 'state' (type state_t) for checkers.
// -----------------------------------------------------------------------------
module clmul_incr_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] h,
`ifdef CLMUL_FULL_PRODUCT_EN
   output logic [WIDTH-1:0] h_hi,
`endif
   output logic [WIDTH-1:0] m,
   output logic             m_cout,
   output logic             busy
);

`ifdef CLMUL_FULL_PRODUCT_EN
   localparam int ACC_W = 2 * WIDTH;
`else
   localparam int ACC_W = WIDTH;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             last_step;
   logic [ACC_W-1:0] b_ext;
   logic [ACC_W-1:0] acc_next;

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next-state and handshake outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_next = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            // Returning to IDLE here means an in_valid presented alongside
            // out_ready is only taken on the following cycle.
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign accept    = (state == IDLE) && in_valid;
   assign last_step = (cnt == CNT_W'(WIDTH - 1));

   // Shifted partial product. With the full-product accumulator the shift keeps
   // every bit; otherwise bits above WIDTH-1 fall off, giving the truncated
   // low half directly.
   assign b_ext    = ACC_W'(b_reg);
   assign acc_next = a_reg[cnt] ? (acc ^ (b_ext << cnt)) : acc;

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg  <= '0;
         b_reg  <= '0;
         acc    <= '0;
         cnt    <= '0;
         h      <= '0;
`ifdef CLMUL_FULL_PRODUCT_EN
         h_hi   <= '0;
`endif
         m      <= '0;
         m_cout <= 1'b0;
      end else begin
         if (accept) begin
            a_reg         <= a;
            b_reg         <= b;
            acc           <= '0;
            cnt           <= '0;
            // Increment done at WIDTH+1 bits so the carry lands in m_cout.
            {m_cout, m}   <= (WIDTH+1)'(b) + (WIDTH+1)'(c);
         end else if (state == CALC) begin
            acc <= acc_next;
            if (last_step) begin
               h <= acc_next[WIDTH-1:0];
`ifdef CLMUL_FULL_PRODUCT_EN
               h_hi <= acc_next[ACC_W-1:WIDTH];
`endif
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clmul_incr_seq.sv
// -----------------------------------------------------------------------------
// tb_clmul_incr_seq
//
// Directed bench for clmul_incr_seq. Two instances are exercised: WIDTH=8
// (u8) and WIDTH=2 (u2, compared against the legacy combinational equations).
// Latency is counted in rising edges, the accepting edge counting as the first,
// so DONE entry is edge WIDTH+1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clmul_incr_seq;

   int checks = 0;
   int errors = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // WIDTH = 8 instance signals
   logic       in_valid8 = 1'b0;
   logic       in_ready8;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       c8 = 1'b0;
   logic       out_valid8;
   logic       out_ready8 = 1'b0;
   logic [7:0] h8;
   logic [7:0] m8;
   logic       m_cout8;
   logic       busy8;
`ifdef CLMUL_FULL_PRODUCT_EN
   logic [7:0] h_hi8;
`endif

   // WIDTH = 2 instance signals
   logic       in_valid2 = 1'b0;
   logic       in_ready2;
   logic [1:0] a2 = '0;
   logic [1:0] b2 = '0;
   logic       c2 = 1'b0;
   logic       out_valid2;
   logic       out_ready2 = 1'b0;
   logic [1:0] h2;
   logic [1:0] m2;
   logic       m_cout2;
   logic       busy2;
`ifdef CLMUL_FULL_PRODUCT_EN
   logic [1:0] h_hi2;
`endif

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   always #5 clk = ~clk;

   clmul_incr_seq #(.WIDTH(8)) u8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid8),
      .in_ready  (in_ready8),
      .a         (a8),
      .b         (b8),
      .c         (c8),
      .out_valid (out_valid8),
      .out_ready (out_ready8),
      .h         (h8),
`ifdef CLMUL_FULL_PRODUCT_EN
      .h_hi      (h_hi8),
`endif
      .m         (m8),
      .m_cout    (m_cout8),
      .busy      (busy8)
   );

   clmul_incr_seq #(.WIDTH(2)) u2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid2),
      .in_ready  (in_ready2),
      .a         (a2),
      .b         (b2),
      .c         (c2),
      .out_valid (out_valid2),
      .out_ready (out_ready2),
      .h         (h2),
`ifdef CLMUL_FULL_PRODUCT_EN
      .h_hi      (h_hi2),
`endif
      .m         (m2),
      .m_cout    (m_cout2),
      .busy      (busy2)
   );

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   // Present one operand set, then count edges (accepting edge = 1) until
   // out_valid is seen. Gives up at 40 edges; callers flag that as a latency
   // error.
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      output int lat);
      @(negedge clk);
      a8 = ta; b8 = tb; c8 = tc; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      lat = 1;
      while (!out_valid8 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic op2(input logic [1:0] ta, input logic [1:0] tb, input logic tc,
                      output int lat);
      @(negedge clk);
      a2 = ta; b2 = tb; c2 = tc; in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      lat = 1;
      while (!out_valid2 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain8();
      @(negedge clk);
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
   endtask

   task automatic drain2();
      @(negedge clk);
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready8, out_valid8, busy8} !== 3'b100) begin
         errors++;
         $display("FAIL reset_hs8 got rdy/vld/busy=%b want 100", {in_ready8, out_valid8, busy8});
      end
      checks++;
      if ({h8, m8, m_cout8} !== 17'd0) begin
         errors++;
         $display("FAIL reset_out8 got h=%h m=%h cout=%b want 0", h8, m8, m_cout8);
      end
      checks++;
      if ({in_ready2, out_valid2, busy2, h2, m2, m_cout2} !== 8'b1000_0000) begin
         errors++;
         $display("FAIL reset_w2 got rdy=%b vld=%b busy=%b h=%b m=%b cout=%b",
                  in_ready2, out_valid2, busy2, h2, m2, m_cout2);
      end
`ifdef CLMUL_FULL_PRODUCT_EN
      checks++;
      if ({h_hi8, h_hi2} !== 10'd0) begin
         errors++;
         $display("FAIL reset_hhi got %h/%b want 0", h_hi8, h_hi2);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_w2_basic();
      int lat;
      op2(2'd3, 2'd3, 1'b1, lat);
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL w2_latency got %0d want 3", lat);
      end
      checks++;
      if ({h2, m2, m_cout2} !== 5'b01_00_1) begin
         errors++;
         $display("FAIL w2_result got h=%b m=%b cout=%b want h=01 m=00 cout=1", h2, m2, m_cout2);
      end
`ifdef CLMUL_FULL_PRODUCT_EN
      checks++;
      if (h_hi2 !== 2'b01) begin
         errors++;
         $display("FAIL w2_hhi got %b want 01", h_hi2);
      end
`endif
      drain2();
      checks++;
      if ({out_valid2, in_ready2} !== 2'b01) begin
         errors++;
         $display("FAIL w2_drain got vld/rdy=%b want 01", {out_valid2, in_ready2});
      end
   endtask

   task automatic test_basic8();
      int lat;
      op8(8'h80, 8'h03, 1'b0, lat);
      checks++;
      if (lat !== 9) begin
         errors++;
         $display("FAIL b8_latency got %0d want 9", lat);
      end
      checks++;
      if ({h8, m8, m_cout8} !== {8'h80, 8'h03, 1'b0}) begin
         errors++;
         $display("FAIL b8_a80 got h=%h m=%h cout=%b want h=80 m=03 cout=0", h8, m8, m_cout8);
      end
`ifdef CLMUL_FULL_PRODUCT_EN
      checks++;
      if (h_hi8 !== 8'h01) begin
         errors++;
         $display("FAIL b8_a80_hhi got %h want 01", h_hi8);
      end
`endif
      drain8();
      // Results must persist after the handshake.
      checks++;
      if ({out_valid8, in_ready8, h8, m8} !== {2'b01, 8'h80, 8'h03}) begin
         errors++;
         $display("FAIL b8_hold got vld=%b rdy=%b h=%h m=%h", out_valid8, in_ready8, h8, m8);
      end

      op8(8'hFF, 8'h01, 1'b1, lat);
      checks++;
      if ({h8, m8, m_cout8} !== {8'hFF, 8'h02, 1'b0} || lat !== 9) begin
         errors++;
         $display("FAIL b8_aff got h=%h m=%h cout=%b lat=%0d want h=ff m=02 cout=0 lat=9",
                  h8, m8, m_cout8, lat);
      end
`ifdef CLMUL_FULL_PRODUCT_EN
      checks++;
      if (h_hi8 !== 8'h00) begin
         errors++;
         $display("FAIL b8_aff_hhi got %h want 00", h_hi8);
      end
`endif
      drain8();
   endtask

   task automatic test_wrap_zero();
      int lat;
      // a = 0 still runs the full WIDTH steps; b = ff, c = 1 wraps the increment.
      op8(8'h00, 8'hFF, 1'b1, lat);
      checks++;
      if (lat !== 9) begin
         errors++;
         $display("FAIL zero_latency got %0d want 9", lat);
      end
      checks++;
      if ({h8, m8, m_cout8} !== {8'h00, 8'h00, 1'b1}) begin
         errors++;
         $display("FAIL wrap got h=%h m=%h cout=%b want h=00 m=00 cout=1", h8, m8, m_cout8);
      end
      drain8();
      op8(8'h01, 8'hA5, 1'b0, lat);
      checks++;
      if ({h8, m8, m_cout8} !== {8'hA5, 8'hA5, 1'b0}) begin
         errors++;
         $display("FAIL b_plus0 got h=%h m=%h cout=%b want h=a5 m=a5 cout=0", h8, m8, m_cout8);
      end
      drain8();
   endtask

   task automatic test_backpressure();
      int lat;
      int seen;
      // 0x05 (x) 0x03 = 0x05 ^ 0x0a = 0x0f
      op8(8'h05, 8'h03, 1'b0, lat);
      @(negedge clk);
      a8 = 8'h11; b8 = 8'h22; c8 = 1'b1; in_valid8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({out_valid8, in_ready8, h8, m8} !== {2'b10, 8'h0F, 8'h03}) begin
            errors++;
            $display("FAIL bp_hold[%0d] got vld=%b rdy=%b h=%h m=%h want 1 0 0f 03",
                     i, out_valid8, in_ready8, h8, m8);
         end
      end
      @(negedge clk);
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      // Back in IDLE; the in_valid seen with out_ready was not taken.
      checks++;
      if ({out_valid8, in_ready8, busy8, m8} !== {3'b010, 8'h03}) begin
         errors++;
         $display("FAIL bp_release got vld=%b rdy=%b busy=%b m=%h want 0 1 0 03",
                  out_valid8, in_ready8, busy8, m8);
      end
      @(negedge clk);
      out_ready8 = 1'b0;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      checks++;
      if ({in_ready8, busy8, m8, m_cout8} !== {2'b01, 8'h23, 1'b0}) begin
         errors++;
         $display("FAIL bp_accept got rdy=%b busy=%b m=%h cout=%b want 0 1 23 0",
                  in_ready8, busy8, m8, m_cout8);
      end
      seen = 1;
      while (!out_valid8 && seen < 40) begin
         @(posedge clk); #1;
         seen++;
      end
      // 0x11 (x) 0x22 = 0x022 ^ 0x220 = 0x202
      checks++;
      if (h8 !== 8'h02 || seen !== 9) begin
         errors++;
         $display("FAIL bp_second got h=%h lat=%0d want h=02 lat=9", h8, seen);
      end
`ifdef CLMUL_FULL_PRODUCT_EN
      checks++;
      if (h_hi8 !== 8'h02) begin
         errors++;
         $display("FAIL bp_second_hhi got %h want 02", h_hi8);
      end
`endif
      drain8();
   endtask

   task automatic test_reset_mid();
      int stale;
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h55; c8 = 1'b1; in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      // cnt = 0 now; three more edges put the block on step 3.
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({in_ready8, out_valid8, busy8, h8, m8, m_cout8} !== {3'b100, 17'd0}) begin
         errors++;
         $display("FAIL rst_mid got rdy=%b vld=%b busy=%b h=%h m=%h cout=%b want 1 0 0 00 00 0",
                  in_ready8, out_valid8, busy8, h8, m8, m_cout8);
      end
      @(negedge clk);
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid8 || busy8) stale++;
      end
      checks++;
      if (stale !== 0) begin
         errors++;
         $display("FAIL rst_stale got %0d active cycles want 0", stale);
      end
   endtask

   task automatic test_sweep_w2();
      int lat;
      logic [1:0] ea;
      logic [1:0] eb;
      logic       ec;
      logic [1:0] exp_h;
      logic [1:0] exp_m;
      logic       exp_cout;
      for (int v = 0; v < 32; v++) begin
         ea = v[4:3];
         eb = v[2:1];
         ec = v[0];
         exp_h[0] = ea[0] & eb[0];
         exp_h[1] = (ea[1] & eb[0]) ^ (ea[0] & eb[1]);
         exp_m[0] = eb[0] ^ ec;
         exp_m[1] = eb[1] ^ (eb[0] & ec);
         exp_cout = eb[1] & eb[0] & ec;
         op2(ea, eb, ec, lat);
         checks++;
         if ({h2, m2, m_cout2} !== {exp_h, exp_m, exp_cout} || lat !== 3) begin
            errors++;
            $display("FAIL sweep a=%b b=%b c=%b got h=%b m=%b cout=%b lat=%0d want h=%b m=%b cout=%b lat=3",
                     ea, eb, ec, h2, m2, m_cout2, lat, exp_h, exp_m, exp_cout);
         end
`ifdef CLMUL_FULL_PRODUCT_EN
         checks++;
         if (h_hi2 !== {1'b0, ea[1] & eb[1]}) begin
            errors++;
            $display("FAIL sweep_hhi a=%b b=%b got %b want %b", ea, eb, h_hi2, {1'b0, ea[1] & eb[1]});
         end
`endif
         drain2();
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_w2_basic();
      test_basic8();
      test_wrap_zero();
      test_backpressure();
      test_reset_mid();
      test_sweep_w2();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clmul_incr_seq.md
Name: clmul_incr_seq

Overview:
- Parametrised, sequential successor to the 2-bit combinational carry-less-multiply / increment cell.
- Accepts WIDTH-bit operands a, b and a 1-bit carry-in c over a valid/ready handshake.
- Computes h = low WIDTH bits of the carry-less (GF(2)) product a⊗b by shift-and-XOR, one bit of a per cycle.
- Also computes the WIDTH-bit increment m = b + c with carry-out. Intended as a matching-benchmark building block and as a serial GF(2) datapath primitive.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the internal bit-step counter; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand set presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier; also the increment operand
- c  input  1  increment carry-in
- out_valid  output  1  results valid
- out_ready  input  1  consumer accepts results
- h  output  WIDTH  low WIDTH bits of a⊗b (carry-less)
- m  output  WIDTH  (b + c) mod 2^WIDTH
- m_cout  output  1  carry-out of b + c
- busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0.
  - h, m, m_cout = 0; internal a_reg, b_reg, acc, cnt = 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a_reg = a, b_reg = b, acc = 0, cnt = 0.
  - Register {m_cout, m} = b + c, computed at WIDTH+1 bits.
  - Go to CALC.
  - Inputs are ignored when in_valid = 0.
- CALC:
  - in_ready = 0.
  - Each cycle: if a_reg[cnt] = 1, then acc ^= (b_reg << cnt) truncated to WIDTH bits; cnt++.
  - When cnt = WIDTH-1 the final step executes and the state goes to DONE; h is loaded with the final acc value on the same edge.
  - Exactly WIDTH CALC cycles.
- DONE:
  - out_valid = 1; h, m, m_cout are held stable.
  - When out_ready = 1: out_valid drops on the next edge and the state returns to IDLE.
  - No accept is possible in DONE, because in_ready = 0.
- Latency: out_valid rises WIDTH+1 edges after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles minimum (with out_ready tied high).
- Output stability: h, m, m_cout change only on accept (m, m_cout) or on the DONE entry edge (h). They keep their last values after the handshake until the next operation.
- Backpressure: out_ready held low keeps DONE indefinitely, with outputs stable and input ignored.
- Zero operands: a = 0 still takes the full WIDTH cycles; h = 0. No early termination.
- Wrap-around: b = 2^WIDTH-1 with c = 1 gives m = 0, m_cout = 1. b + 0 gives m = b, m_cout = 0.
- Reset mid-operation: rst in CALC or DONE aborts on that edge; all outputs return to reset values and the result is discarded.
- Simultaneous events: rst has priority over every handshake. in_valid asserted in the same cycle as the out_ready handshake is not accepted; it is accepted the following cycle in IDLE.
- WIDTH = 2 consistency: the outputs equal the legacy combinational cell.
  - h[0] = a0·b0
  - h[1] = a1·b0 ⊕ a0·b1
  - m[0] = b0 ⊕ c
  - m[1] = b1 ⊕ (b0·c)

Optional Feature:
- Macro: CLMUL_FULL_PRODUCT_EN.
- When defined:
  - Adds output port h_hi (WIDTH bits), the upper WIDTH bits of the full 2·WIDTH-1-bit carry-less product.
  - The accumulator becomes 2·WIDTH bits, and shifted b is not truncated.
  - h_hi[WIDTH-1] is always 0.
  - h_hi follows the same reset, load and hold rules as h.
- When undefined: the port is absent, and the accumulator is WIDTH bits.

Test Plan:
- WIDTH=2, a=3, b=3, c=1, out_ready=1 -> out_valid 3 edges after accept; h=2'b01, m=2'b00, m_cout=1; with CLMUL_FULL_PRODUCT_EN, h_hi=2'b01.
- WIDTH=8, a=0x80, b=0x03, c=0 -> h=0x80, m=0x03, m_cout=0; h_hi=0x01 when the macro is on; out_valid exactly 9 edges after accept.
- WIDTH=8, a=0xFF, b=0x01, c=1 -> h=0xFF, m=0x02, m_cout=0; h_hi=0x00. Then b=0xFF, c=1 -> m=0x00, m_cout=1.
- Backpressure: result pending with out_ready=0 for 5 cycles, in_valid=1 with new operands -> out_valid stays 1, h/m unchanged, in_ready=0. out_ready=1 -> IDLE, and the new operands are accepted one cycle later.
- Reset mid-CALC (rst high at CALC step 3, WIDTH=8) -> next cycle state IDLE, in_ready=1, out_valid=0, h=m=0, m_cout=0; no stale result appears.
- Exhaustive sweep WIDTH=2, all 32 {a,b,c} -> h, m, m_cout equal the legacy combinational equations above.
